// File: rtl/ex_divider_pkg.sv
// ----------------------------------------------------------------------------
// ex_divider_pkg
// Shared definitions for the EX-stage integer divider: division operation
// encodings, FSM state encoding, iteration-count constants and small helpers.
// Optional feature macro used by the divider top: DIV_STATS_EN.
// ----------------------------------------------------------------------------
package ex_divider_pkg;

  // op_i encodings
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Iteration counter: wide enough to hold 64
  localparam int                CNT_W   = 7;
  localparam logic [CNT_W-1:0]  ITER_64 = 7'd64;
  localparam logic [CNT_W-1:0]  ITER_32 = 7'd32;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/ex_divider_core.sv
// ----------------------------------------------------------------------------
// div_core
// Unsigned radix-2 restoring shift-subtract datapath. Holds the partial
// remainder, the quotient/dividend shift register, the divisor and the
// iteration counter.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   synchronous active-low reset (clears all registers)
//   i_load      in   load operands, clear remainder, load iteration count
//   i_step      in   perform one quotient-bit iteration
//   i_dividend  in   64  unsigned dividend (left-justified for 32-bit ops)
//   i_divisor   in   64  unsigned divisor
//   i_count     in   CNT_W  number of iterations to perform
//   o_finished  out  the current step is the last one (counter == 1)
//   o_quo       out  64  quotient register
//   o_rem       out  64  remainder register
// ----------------------------------------------------------------------------
module div_core
  import ex_divider_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [63:0]      i_dividend,
  input  logic [63:0]      i_divisor,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_finished,
  output logic [63:0]      o_quo,
  output logic [63:0]      o_rem
);

  logic [63:0]      r_rem;
  logic [63:0]      r_quo;
  logic [63:0]      r_dsr;
  logic [CNT_W-1:0] r_cnt;

  // The shifted remainder needs 65 bits: with a divisor above 2^63 the
  // doubled partial remainder can exceed 64 bits before the subtract.
  logic [64:0]      w_shift;
  logic             w_ge;
  logic [63:0]      w_diff;

  assign w_shift = {r_rem, r_quo[63]};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});
  // When w_ge holds the true difference is below 2^64, so the low 64 bits
  // of the modular subtraction are exact.
  assign w_diff  = w_shift[63:0] - r_dsr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dsr <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dsr <= i_divisor;
      r_cnt <= i_count;
    end else if (i_step) begin
      r_rem <= w_ge ? w_diff : w_shift[63:0];
      r_quo <= {r_quo[62:0], w_ge};
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_finished = (r_cnt == CNT_W'(1));
  assign o_quo      = r_quo;
  assign o_rem      = r_rem;

endmodule

// File: rtl/ex_divider.sv
// ----------------------------------------------------------------------------
// ex_divider
// Multi-cycle integer divider for the rv64IM EX stage: DIV/DIVU/REM/REMU and
// their W forms. Divide-by-zero and signed overflow resolve combinationally
// in the start cycle; all other operations run through div_core with a stall
// request held until the result is presented in DONE.
//
// Optional feature macro: DIV_STATS_EN (adds nr_divs_o, div_stall_cycles_o).
//
// Ports
//   clock               in   pipeline clock
//   reset_n             in   synchronous active-low reset
//   start_i             in   EX holds a divide-class instruction
//   op_i                in   2  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   word_i              in   W variant (operand bits [31:0])
//   dividend_i          in   XLEN rs1 value
//   divisor_i           in   XLEN rs2 value
//   flush_i             in   kill the in-flight operation
//   div_stall_o         out  stall request to the hazard controller
//   done_o              out  result_o valid this cycle
//   result_o            out  XLEN quotient or remainder
//   nr_divs_o           out  64  completed divides       (DIV_STATS_EN)
//   div_stall_cycles_o  out  64  cycles with stall high  (DIV_STATS_EN)
// ----------------------------------------------------------------------------
module ex_divider
  import ex_divider_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            div_stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
`ifdef DIV_STATS_EN
  ,
  output logic [63:0]     nr_divs_o,
  output logic [63:0]     div_stall_cycles_o
`endif
);

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------- operands
  logic        w_signed;
  logic        w_is_rem;
  logic [63:0] w_dvd_ext;
  logic [63:0] w_dsr_ext;
  logic        w_dvd_neg;
  logic        w_dsr_neg;
  logic [63:0] w_dvd_abs;
  logic [63:0] w_dsr_abs;
  logic [63:0] w_dvd_load;

  assign w_signed = (op_i == OP_DIV) || (op_i == OP_REM);
  assign w_is_rem = (op_i == OP_REM) || (op_i == OP_REMU);

  assign w_dvd_ext = !word_i  ? dividend_i :
                     w_signed ? sext32(dividend_i[31:0]) : {32'b0, dividend_i[31:0]};
  assign w_dsr_ext = !word_i  ? divisor_i :
                     w_signed ? sext32(divisor_i[31:0])  : {32'b0, divisor_i[31:0]};

  assign w_dvd_neg = w_signed & w_dvd_ext[63];
  assign w_dsr_neg = w_signed & w_dsr_ext[63];
  // |most-negative| wraps back to itself, which is the correct unsigned value.
  assign w_dvd_abs = w_dvd_neg ? neg64(w_dvd_ext) : w_dvd_ext;
  assign w_dsr_abs = w_dsr_neg ? neg64(w_dsr_ext) : w_dsr_ext;
  // 32-bit ops run 32 iterations, so the dividend is left-justified to feed
  // its MSB into the remainder first.
  assign w_dvd_load = word_i ? {w_dvd_abs[31:0], 32'b0} : w_dvd_abs;

  // ----------------------------------------------------------- special cases
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [63:0] w_special_raw;
  logic [63:0] w_special_res;

  assign w_div_zero = word_i ? (divisor_i[31:0] == 32'd0) : (divisor_i == '0);
  assign w_ovf      = w_signed &
                      (word_i ? ((dividend_i[31:0] == 32'h8000_0000) &&
                                 (divisor_i[31:0]  == 32'hFFFF_FFFF))
                              : ((dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                                 (divisor_i  == '1)));
  assign w_special  = w_div_zero | w_ovf;

  assign w_special_raw = w_div_zero ? (w_is_rem ? dividend_i : '1)
                                    : (w_is_rem ? '0 : dividend_i);
  assign w_special_res = word_i ? sext32(w_special_raw[31:0]) : w_special_raw;

  logic w_accept;
  assign w_accept = (r_state == ST_IDLE) && start_i && !flush_i && !w_special;

  // ---------------------------------------------------------------- datapath
  logic        w_core_fin;
  logic [63:0] w_core_quo;
  logic [63:0] w_core_rem;

  div_core u_core (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (w_accept),
    .i_step     (r_state == ST_CALC),
    .i_dividend (w_dvd_load),
    .i_divisor  (w_dsr_abs),
    .i_count    (word_i ? ITER_32 : ITER_64),
    .o_finished (w_core_fin),
    .o_quo      (w_core_quo),
    .o_rem      (w_core_rem)
  );

  // Operation attributes captured at acceptance, used during FIX
  logic        r_word;
  logic        r_is_rem;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;

  logic [63:0] w_quo_fix;
  logic [63:0] w_rem_fix;
  logic [63:0] w_sel;
  logic [63:0] w_fix_res;

  assign w_quo_fix = r_neg_q ? neg64(w_core_quo) : w_core_quo;
  assign w_rem_fix = r_neg_r ? neg64(w_core_rem) : w_core_rem;
  assign w_sel     = r_is_rem ? w_rem_fix : w_quo_fix;
  assign w_fix_res = r_word ? sext32(w_sel[31:0]) : w_sel;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_word   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_word   <= word_i;
        r_is_rem <= w_is_rem;
        r_neg_q  <= w_dvd_neg ^ w_dsr_neg;
        r_neg_r  <= w_dvd_neg;
      end
      if (r_state == ST_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC: begin
        if (flush_i)         w_state_nxt = ST_IDLE;
        else if (w_core_fin) w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = flush_i ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stall is combinational from start_i in IDLE so the controller freezes
  // the front end in the same cycle the divide reaches EX.
  always_comb begin
    div_stall_o = 1'b0;
    done_o      = 1'b0;
    result_o    = '0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          if (w_special) begin
            done_o   = 1'b1;
            result_o = w_special_res;
          end else begin
            div_stall_o = 1'b1;
          end
        end
      end
      ST_CALC, ST_FIX: div_stall_o = 1'b1;
      ST_DONE: begin
        if (!flush_i) begin
          done_o   = 1'b1;
          result_o = r_result;
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------- statistics
`ifdef DIV_STATS_EN
  logic [63:0] r_nr_divs;
  logic [63:0] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_nr_divs      <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (done_o)      r_nr_divs      <= r_nr_divs + 64'd1;
      if (div_stall_o) r_stall_cycles <= r_stall_cycles + 64'd1;
    end
  end

  assign nr_divs_o          = r_nr_divs;
  assign div_stall_cycles_o = r_stall_cycles;
`endif

endmodule

// File: tb/tb_ex_divider.sv
// ----------------------------------------------------------------------------
// tb_ex_divider
// Self-checking bench for ex_divider: directed scenarios plus randomized
// operations compared against an arithmetic reference model. Build with
// DIV_STATS_EN defined to also check the statistics counters.
// ----------------------------------------------------------------------------
module tb_ex_divider;

  localparam logic [1:0] T_DIV  = 2'b00;
  localparam logic [1:0] T_DIVU = 2'b01;
  localparam logic [1:0] T_REM  = 2'b10;
  localparam logic [1:0] T_REMU = 2'b11;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        start_i    = 1'b0;
  logic [1:0]  op_i       = 2'b00;
  logic        word_i     = 1'b0;
  logic [63:0] dividend_i = '0;
  logic [63:0] divisor_i  = '0;
  logic        flush_i    = 1'b0;
  logic        div_stall_o;
  logic        done_o;
  logic [63:0] result_o;
`ifdef DIV_STATS_EN
  logic [63:0] nr_divs_o;
  logic [63:0] div_stall_cycles_o;
`endif

  int          checks    = 0;
  int          failures  = 0;
  logic [63:0] exp_nr    = '0;
  logic [63:0] exp_stall = '0;

  always #5 clock = ~clock;

  ex_divider #(.XLEN(64)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .word_i      (word_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .flush_i     (flush_i),
    .div_stall_o (div_stall_o),
    .done_o      (done_o),
    .result_o    (result_o)
`ifdef DIV_STATS_EN
    ,
    .nr_divs_o          (nr_divs_o),
    .div_stall_cycles_o (div_stall_cycles_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics computed with plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
    logic        is_rem;
    logic        uns;
    logic [31:0] r32;
    int          sa32;
    int          sb32;
    longint      sa;
    longint      sb;
    logic [63:0] r64;
    is_rem = op[1];
    uns    = op[0];
    if (word) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'd0)
        r32 = is_rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = is_rem ? 32'd0 : a[31:0];
      else if (uns)
        r32 = is_rem ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      else
        r32 = is_rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      return {{32{r32[31]}}, r32};
    end
    sa = a;
    sb = b;
    if (b == 64'd0)
      r64 = is_rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r64 = is_rem ? 64'd0 : a;
    else if (uns)
      r64 = is_rem ? (a % b) : (a / b);
    else
      r64 = is_rem ? 64'(sa % sb) : 64'(sa / sb);
    return r64;
  endfunction

  function automatic bit ref_special(input logic [1:0] op, input logic word,
                                     input logic [63:0] a, input logic [63:0] b);
    if (word)
      return (b[31:0] == 32'd0) ||
             (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) ||
           (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  // Issue one divide, hold start until done, measure stall cycles and latency.
  task automatic do_div(input logic [1:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input string tag);
    logic [63:0] exp;
    int          n;
    int          cycles;
    int          stalls;
    exp = ref_result(op, word, a, b);
    n   = ref_special(op, word, a, b) ? 0 : (word ? 34 : 66);
    @(negedge clock);
    start_i    = 1'b1;
    op_i       = op;
    word_i     = word;
    dividend_i = a;
    divisor_i  = b;
    #1;
    cycles = 0;
    stalls = 0;
    while (done_o !== 1'b1 && cycles < 200) begin
      if (div_stall_o === 1'b1) stalls++;
      @(negedge clock);
      #1;
      cycles++;
    end
    check({tag, " done"},         64'(done_o),      64'd1);
    check({tag, " result"},       result_o,         exp);
    check({tag, " stall_at_done"}, 64'(div_stall_o), 64'd0);
    check({tag, " stall_cycles"}, 64'(stalls),      64'(n));
    check({tag, " latency"},      64'(cycles),      64'(n));
    exp_nr    = exp_nr + 64'd1;
    exp_stall = exp_stall + 64'(n);
    // start is still high through the DONE cycle; dropping it now must show
    // a quiet IDLE, proving DONE did not restart the operation.
    @(negedge clock);
    start_i = 1'b0;
    #1;
    check({tag, " idle_flags"},  {62'd0, done_o, div_stall_o}, 64'd0);
    check({tag, " idle_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic        r_word;
    logic [63:0] r_a;
    logic [63:0] r_b;

    // ---- reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("reset stall",  64'(div_stall_o), 64'd0);
    check("reset done",   64'(done_o),      64'd0);
    check("reset result", result_o,         64'd0);
`ifdef DIV_STATS_EN
    check("reset nr_divs",      nr_divs_o,          64'd0);
    check("reset stall_cycles", div_stall_cycles_o, 64'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    // ---- directed operations
    do_div(T_DIV,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, "div_100_m7");
    do_div(T_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, "remu_max_10");
    do_div(T_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "divw_ovf");
    do_div(T_DIVU, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, "divu_by0");
    do_div(T_REM,  1'b0, 64'd37, 64'd0, "rem_37_by0");
    do_div(T_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div_ovf64");
    do_div(T_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, "rem_m100_7");
    do_div(T_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, "divu_bigdsr");
    do_div(T_REMU, 1'b1, 64'hDEAD_BEEF_FFFF_FFF0, 64'h0000_0000_0000_0007, "remuw");

    // ---- flush at CALC cycle 20
    @(negedge clock);
    start_i    = 1'b1;
    op_i       = T_DIV;
    word_i     = 1'b0;
    dividend_i = 64'd1000;
    divisor_i  = 64'd3;
    #1;
    check("flush start stall", 64'(div_stall_o), 64'd1);
    repeat (20) @(negedge clock);
    #1;
    check("flush calc20 stall", 64'(div_stall_o), 64'd1);
    check("flush calc20 done",  64'(done_o),      64'd0);
    flush_i = 1'b1;
    @(negedge clock);
    #1;
    check("flush next done",  64'(done_o),      64'd0);
    check("flush next stall", 64'(div_stall_o), 64'd0);
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    check("flush idle flags", {62'd0, done_o, div_stall_o}, 64'd0);
    do_div(T_DIVU, 1'b1, 64'd7, 64'd2, "divuw_7_2");

    // ---- reset mid-CALC
    @(negedge clock);
    start_i    = 1'b1;
    op_i       = T_DIV;
    word_i     = 1'b0;
    dividend_i = 64'd12345;
    divisor_i  = 64'd67;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    start_i = 1'b0;
    @(negedge clock);
    #1;
    check("rst_mid stall",  64'(div_stall_o), 64'd0);
    check("rst_mid done",   64'(done_o),      64'd0);
    check("rst_mid result", result_o,         64'd0);
`ifdef DIV_STATS_EN
    check("rst_mid nr_divs",      nr_divs_o,          64'd0);
    check("rst_mid stall_cycles", div_stall_cycles_o, 64'd0);
`endif
    reset_n   = 1'b1;
    exp_nr    = '0;
    exp_stall = '0;
    do_div(T_DIV, 1'b0, 64'd12345, 64'd67, "after_reset");

    // ---- randomized operations
    for (int i = 0; i < 14; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_word = 1'($urandom_range(0, 1));
      r_a    = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       r_b = {$urandom, $urandom};
        1:       r_b = 64'($urandom_range(1, 20));
        2:       r_b = ~64'($urandom_range(0, 20)) + 64'd1;
        3:       r_b = {32'd0, $urandom};
        default: r_b = 64'd0;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        r_a = r_word ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        r_b = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      do_div(r_op, r_word, r_a, r_b, $sformatf("rand%0d", i));
    end

`ifdef DIV_STATS_EN
    check("stats nr_divs",      nr_divs_o,          exp_nr);
    check("stats stall_cycles", div_stall_cycles_o, exp_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
